// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes, dmem wait freeze with watchdog.
// Define PIPE_HAZARD_PERF_CNT_EN to build the saturating hazard performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_rd_wren,
  input  logic             i_ex_mem_ren,
  input  logic             i_ex_redirect,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ack,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_pipe_freeze,
  output logic             o_mem_timeout
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] wd_cnt;
  logic       lu;
  logic       mw;
  logic       run_wait;
  logic       run_redirect;
  logic       run_stall;

  // RUN-state decisions in priority order: wait beats redirect beats load-use.
  always_comb begin
    lu = i_ex_mem_ren && i_ex_rd_wren && (i_ex_rd_addr != 5'd0) &&
         (((i_ex_rd_addr == i_id_rs1_addr) && i_id_rs1_used) ||
          ((i_ex_rd_addr == i_id_rs2_addr) && i_id_rs2_used));
    mw           = i_dmem_req && !i_dmem_ack;
    run_wait     = (state == RUN) && mw;
    run_redirect = (state == RUN) && !mw && i_ex_redirect;
    run_stall    = (state == RUN) && !mw && !i_ex_redirect && lu;
  end

  // Outputs are forced to the free-running pattern while reset is held.
  always_comb begin
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_pipe_freeze = 1'b0;
    if (i_reset) begin
      if (run_wait || (state == MEM_WAIT)) begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_pipe_freeze = 1'b1;
      end else if (run_redirect || (state == TIMEOUT)) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (run_stall) begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= RUN;
      wd_cnt        <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            state  <= MEM_WAIT;
            wd_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          wd_cnt <= wd_cnt + 8'd1;
          // An ack on the final allowed cycle still completes normally.
          if (i_dmem_ack) begin
            state <= RUN;
          end else if (wd_cnt == 8'(WAIT_MAX)) begin
            state         <= TIMEOUT;
            o_mem_timeout <= 1'b1;
          end
        end
        TIMEOUT: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
      o_wait_cnt  <= '0;
    end else begin
      if (run_stall && (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + 1'b1;
      if (run_redirect && (o_flush_cnt != '1))
        o_flush_cnt <= o_flush_cnt + 1'b1;
      if ((state == MEM_WAIT) && (o_wait_cnt != '1))
        o_wait_cnt <= o_wait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the IF/ID and ID/EX pipeline registers and drives their enable and flush inputs. It resolves load-use hazards, branch/jump redirects and data-memory wait states, and has a watchdog for memory stalls that never complete. An optional set of hazard performance counters can be compiled in.

## Interface
Parameters:
- WAIT_MAX, default 16: maximum number of cycles spent in MEM_WAIT before a timeout. Legal range 2..255.
- CNT_W, default 32: width of each performance counter.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_id_rs1_addr  in  5  rs1 index of the instruction in ID.
- i_id_rs2_addr  in  5  rs2 index of the instruction in ID.
- i_id_rs1_used  in  1  the ID instruction reads rs1.
- i_id_rs2_used  in  1  the ID instruction reads rs2.
- i_ex_rd_addr  in  5  rd index of the instruction in EX.
- i_ex_rd_wren  in  1  the EX instruction writes rd.
- i_ex_mem_ren  in  1  the EX instruction is a load.
- i_ex_redirect  in  1  EX resolved a taken branch or jump, so the PC is redirected.
- i_dmem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- i_dmem_ack  in  1  data memory has completed the access.
- o_pc_en  out  1  PC register update enable.
- o_if_id_en  out  1  IF/ID register load enable.
- o_if_id_flush  out  1  squash IF/ID, turning it into a bubble.
- o_id_ex_flush  out  1  squash ID/EX, turning it into a bubble.
- o_pipe_freeze  out  1  hold EX/MEM and MEM/WB.
- o_mem_timeout  out  1  sticky flag: the watchdog has expired.
- o_stall_cnt  out  CNT_W  number of load-use stall cycles (present only when the macro is defined).
- o_flush_cnt  out  CNT_W  number of redirect events (present only when the macro is defined).
- o_wait_cnt  out  CNT_W  number of MEM_WAIT cycles (present only when the macro is defined).

## Operation
- State machine states: RUN, MEM_WAIT, TIMEOUT.
- Load-use condition `lu`, all terms required:
  - i_ex_mem_ren and i_ex_rd_wren are both high;
  - i_ex_rd_addr is not 0;
  - i_ex_rd_addr matches i_id_rs1_addr with i_id_rs1_used high, or matches i_id_rs2_addr with i_id_rs2_used high.
- Memory-wait condition `mw`: i_dmem_req high and i_dmem_ack low.
- RUN, evaluated in priority order:
  1. `mw`: set o_pc_en=0, o_if_id_en=0, o_pipe_freeze=1 and no flushes; go to MEM_WAIT and load the watchdog counter with 1.
  2. i_ex_redirect: set o_if_id_flush=1 and o_id_ex_flush=1, with enables high. A redirect overrides `lu`, because the dependent instruction is squashed anyway.
  3. `lu`: set o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1. This inserts one bubble; the condition clears on the next cycle because the load has moved to MEM.
  4. Otherwise: all enables 1, all flushes 0, freeze 0.
- MEM_WAIT:
  - Outputs are the same as case 1 of RUN, and the watchdog counter increments every cycle.
  - i_dmem_ack=1: go to RUN. The ack cycle itself is still frozen.
  - i_ex_redirect and `lu` are ignored while in MEM_WAIT. Their inputs are held by the freeze, so they are re-evaluated in RUN.
  - Counter equal to WAIT_MAX with no ack: set o_mem_timeout and go to TIMEOUT.
- TIMEOUT: one cycle with o_if_id_flush=1, o_id_ex_flush=1, o_pipe_freeze=0, o_pc_en=1 (the stalled access is abandoned); then go to RUN.
- o_mem_timeout stays high until reset.
- All stage-control outputs are Moore/Mealy combinational functions of the state and the current inputs.

## Timing
- Reset (i_reset=0, asynchronous):
  - state goes to RUN, the watchdog counter to 0, o_mem_timeout to 0, and all counters to 0.
  - While reset is held, the outputs are: o_pc_en=1, o_if_id_en=1, o_if_id_flush=0, o_id_ex_flush=0, o_pipe_freeze=0.
- Hazard response latency:
  - `lu` and redirect responses appear in the same cycle as the condition, with zero added latency.
  - A load-use costs exactly 1 bubble. A redirect costs 2 bubbles.
- MEM_WAIT duration: from the cycle `mw` is first seen through the ack cycle inclusive. The minimum is 2 frozen cycles.
- Watchdog: a timeout is entered after exactly WAIT_MAX cycles in MEM_WAIT without an ack.
  - An ack arriving in the same cycle the counter reaches WAIT_MAX wins: go to RUN and do not set the timeout.
- Reset asserted mid-wait aborts immediately to RUN.
- When `mw` and i_ex_redirect occur in the same cycle, the freeze wins; the redirect is applied on the first RUN cycle after the ack.

## Configuration
- PIPE_HAZARD_PERF_CNT_EN defined:
  - o_stall_cnt, o_flush_cnt and o_wait_cnt exist and saturate at all-ones.
  - o_stall_cnt counts each RUN cycle that takes case 3; o_flush_cnt counts each RUN cycle that takes case 2; o_wait_cnt counts each cycle spent in MEM_WAIT.
- Not defined: the counter ports and their logic are absent. Control behaviour is identical.

## Test plan
- Load-use: EX holds a load with rd=5, ID has rs1=5 with rs1_used=1 → exactly 1 cycle of o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, then normal. Repeating with rd=0 → no stall.
- Redirect plus load-use in the same cycle: i_ex_redirect=1 and `lu` true → o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1. o_stall_cnt does not change and o_flush_cnt increments by 1.
- Memory wait: i_dmem_req=1 with ack arriving 3 cycles later → o_pipe_freeze=1 for 4 cycles, then RUN. With the macro defined, o_wait_cnt=3.
- Watchdog: WAIT_MAX=4, no ack → TIMEOUT entered after 4 MEM_WAIT cycles, one flush cycle, o_mem_timeout=1 and held until reset.
- Ack on the boundary: ack arrives on the WAIT_MAX-th cycle → return to RUN, o_mem_timeout stays 0.
- Reset mid-operation: i_reset pulsed low during MEM_WAIT → freeze drops immediately, all counters read 0, state is RUN.
